// File: rtl/audio_sdm_output_pkg.sv
// Shared constants and helpers for the audio output path.
//   SAMPLE_W       : PCM sample width
//   DEFAULT_RELOAD : sample period in clocks after reset (shared with the controller)
//   MIN_PERIOD     : shortest sample period the timer will run
//   sample_t       : one PCM sample
package audio_pkg;

    localparam int unsigned SAMPLE_W       = 16;
    localparam logic [31:0] DEFAULT_RELOAD = 32'd4536;
    localparam logic [31:0] MIN_PERIOD     = 32'd2;

    typedef logic [15:0] sample_t;

    localparam sample_t SIGN_BIT = 16'h8000;

    // Reload values below MIN_PERIOD would make the request strobe
    // continuous, so they are raised to MIN_PERIOD.
    function automatic logic [31:0] clamp_period(input logic [31:0] reload);
        return (reload < MIN_PERIOD) ? MIN_PERIOD : reload;
    endfunction

    // Signed two's-complement PCM to offset binary (0x8000 = silence).
    function automatic sample_t pcm_to_offset(input sample_t s);
        return s ^ SIGN_BIT;
    endfunction

endpackage

// File: rtl/audio_sdm_output_if.sv
// Link between the audio controller and the sigma-delta output back-end.
//   reload : sample period in clocks   (controller -> back-end)
//   sample : current FIFO head, PCM    (controller -> back-end)
//   busy   : low one cycle per period to request a FIFO read (back-end -> controller)
interface audio_sdm_output_if;
    import audio_pkg::*;

    logic [31:0] reload;
    sample_t     sample;
    logic        busy;

    modport master (output reload, output sample, input busy);
    modport slave  (input reload, input sample, output busy);

endinterface

// File: rtl/audio_sdm_output_sdm.sv
// First-order sigma-delta modulator.
//   i_clock : system clock
//   i_reset : synchronous, active-high reset
//   i_level : offset-binary level; duty cycle of o_bit is i_level / 2**W
//   o_bit   : carry of the accumulator, registered
module audio_sdm
    import audio_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic [W-1:0] i_level,
    output logic         o_bit
);

    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;
    logic         carry_q;
    logic         carry_d;

    always_comb begin
        {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, i_level};
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            carry_q <= carry_d;
        end
    end

    assign o_bit = carry_q;

endmodule

// File: rtl/audio_sdm_output.sv
// Audio output back-end: sample-rate timer, FIFO read request, sample
// capture and 1-bit sigma-delta DAC drive.
//   i_clock : system clock (only clock)
//   i_reset : synchronous, active-high reset
//   ctrl    : reload/sample in, busy out (controller link)
//   o_dac   : sigma-delta bitstream to the board pin / RC filter
module audio_sdm_output #(
    parameter int unsigned LATCH_DELAY = 2,
    parameter int unsigned SAMPLE_W    = 16
) (
    input  logic              i_clock,
    input  logic              i_reset,
    audio_sdm_output_if.slave ctrl,
    output logic              o_dac
);
    import audio_pkg::*;

    localparam logic [SAMPLE_W-1:0] SILENCE = {1'b1, {(SAMPLE_W-1){1'b0}}};

    logic [31:0]            cnt_q;
    logic [31:0]            cnt_d;
    logic                   busy_q;
    logic                   busy_d;
    logic [LATCH_DELAY-1:0] req_pipe_q;
    logic [LATCH_DELAY-1:0] req_pipe_d;
    logic [SAMPLE_W-1:0]    level_q;
    logic [SAMPLE_W-1:0]    level_d;
    logic [31:0]            period_m1;
    logic                   tick;

    // '>=' rather than '==' so that shrinking the reload below the current
    // count ends the period on the very next cycle instead of wrapping.
    always_comb begin
        period_m1 = clamp_period(ctrl.reload) - 32'd1;
        tick      = (cnt_q >= period_m1);
        cnt_d     = tick ? '0 : cnt_q + 32'd1;
        busy_d    = ~tick;
    end

    // Request strobe delayed to line up with the FIFO head becoming valid;
    // the oldest stage triggers the capture.
    always_comb begin
        req_pipe_d    = '0;
        req_pipe_d[0] = ~busy_q;
        for (int unsigned i = 1; i < LATCH_DELAY; i++) begin
            req_pipe_d[i] = req_pipe_q[i-1];
        end
        level_d = req_pipe_q[LATCH_DELAY-1] ? pcm_to_offset(ctrl.sample) : level_q;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            req_pipe_q <= '0;
            level_q    <= SILENCE;
        end else begin
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            req_pipe_q <= req_pipe_d;
            level_q    <= level_d;
        end
    end

    assign ctrl.busy = busy_q;

    audio_sdm #(
        .W (SAMPLE_W)
    ) u_sdm (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_level (level_q),
        .o_bit   (o_dac)
    );

endmodule
